gcd_unit: RTL
=============

Name: gcd_unit

Overview:
- Iterative greatest-common-divisor engine for the arithmetic lab blocks. It is the companion to the multiple-search unit.
- Takes two unsigned operands on a start pulse and runs subtractive Euclid, one subtraction per cycle.
- Presents the result with a level `done` flag that holds until the next start.
- Sits beside the least-common-multiple block; lcm = n1*n2/gcd is computed downstream from this result.

Parameters:
- W, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock, all state changes on posedge.
- rst  input  1  reset, synchronous, active-high. Sampled on posedge clk only.
- start  input  1  request; accepted only in IDLE or DONE.
- n1  input  W  first unsigned operand, sampled on the accepting edge.
- n2  input  W  second unsigned operand, sampled on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  high while in DONE.
- result  output  W  gcd of the last accepted pair. Valid while `done` is high; held until the next start is accepted.
- zero  output  1  high in DONE when both operands were 0 (result 0).

Behaviour:
- State machine: IDLE, CALC, DONE; 2-bit state register.
- Reset (rst high at posedge):
  - state=IDLE; busy=0, done=0, zero=0, result=0; internal a=0, b=0.
  - Reset overrides everything, including mid-CALC: the computation is abandoned and its result is lost.
- IDLE or DONE with start=1:
  - a<=n1, b<=n2; state<=CALC.
  - done and zero drop on that same edge; result is left unchanged until finish.
- IDLE or DONE with start=0: hold.
- CALC, evaluated each edge, in priority order:
  1. a==0 or b==0 or a==b: result<=a|b; zero<=(a==0 && b==0); state<=DONE.
  2. a>b: a<=a-b.
  3. otherwise: b<=b-a.
- start during CALC is ignored, with no queueing. Operand inputs are don't-care outside the accepting edge.
- Subtraction never underflows, because the larger value is always the minuend. No width growth.
- Latency: start edge k, then one CALC edge per subtraction plus one finishing edge.
  - Identical or zero operands finish at edge k+1.
  - Worst case for W bits is gcd(2^W-1, 1): 2^W-1 CALC edges.
- gcd(x,0)=x and gcd(0,x)=x. gcd(0,0)=0 with zero=1.
- Back-to-back operation: start held high in DONE restarts immediately, with no idle cycle required.
- Outputs are driven straight from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- When defined:
  - Adds output port `cycles`, width W.
  - Cleared to 0 on reset and on every accepted start.
  - Increments by 1 on every CALC edge, including the finishing edge. Saturates at all-ones.
  - Holds its value in DONE and IDLE.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package gcd_pkg holds:
  - state typedef (IDLE=2'd0, CALC=2'd1, DONE=2'd2); 2'd3 is illegal and forces IDLE on the next edge.
  - default width constant GCD_W=32.
- One sub-module: gcd_step. It is purely combinational: given a and b it returns next_a, next_b, finish, result_val. It keeps the FSM shell small and is unit-testable alone.

Test Plan:
- rst for 2 cycles, then idle 5 cycles -> busy=0, done=0, zero=0, result=0 throughout.
- start with n1=12, n2=18 at edge k -> busy high k+1..k+2, done=1 and result=6 after edge k+3. With GCD_CYCLE_COUNT_EN, cycles=3.
- n1=7, n2=0 -> done after k+1, result=7, zero=0. Then start with n1=0, n2=0 from DONE -> result=0, zero=1 after the next edge.
- W=8, n1=255, n2=1 -> done exactly 255 edges after start, result=1. start pulses during CALC are ignored and result stays unchanged until finish.
- start 48,36, then rst asserted on the 2nd CALC edge -> IDLE, outputs zero next edge. A following start 48,36 -> result=12, with no residue from the aborted run.
- start held high continuously with operands 21,14 then 9,6 -> results 7 then 3. done is high one cycle between runs and there are no idle gaps.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-Euclid GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One combinational subtractive-Euclid step: either finish with a|b or subtract the smaller value.
module gcd_step import gcd_pkg::*; #(
  parameter int unsigned W = GCD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] next_a,
  output logic [W-1:0] next_b,
  output logic         finish,
  output logic [W-1:0] result_val
);

  always_comb begin
    next_a     = a;
    next_b     = b;
    result_val = a | b;
    finish     = (a == '0) || (b == '0) || (a == b);
    if (!finish) begin
      // The larger value is always the minuend, so neither subtraction can underflow.
      if (a > b) begin
        next_a = a - b;
      end else begin
        next_b = b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine: IDLE -> CALC (one subtraction per cycle) -> DONE.
// Optional GCD_CYCLE_COUNT_EN adds a saturating `cycles` output counting CALC edges.
module gcd_unit import gcd_pkg::*; #(
  parameter int unsigned W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [W-1:0] cycles
`endif
);

  gcd_state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] result_q, result_d;
  logic         zero_q, zero_d;

  logic [W-1:0] step_a, step_b, step_result;
  logic         step_finish;

  gcd_step #(
    .W (W)
  ) u_step (
    .a          (a_q),
    .b          (b_q),
    .next_a     (step_a),
    .next_b     (step_b),
    .finish     (step_finish),
    .result_val (step_result)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = n1;
          b_d     = n2;
          zero_d  = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (step_finish) begin
          result_d = step_result;
          zero_d   = (a_q == '0) && (b_q == '0);
          state_d  = StDone;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign zero   = zero_q;

`ifdef GCD_CYCLE_COUNT_EN
  logic [W-1:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == StIdle || state_q == StDone) && start) begin
      cycles_d = '0;
    end else if (state_q == StCalc && cycles_q != '1) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule
